// File: rtl/t_toggle_counter.sv
// Modulo-MODULUS up/down counter built from toggle flip-flops, with load clamp and wrap pulse.
// Optional Gray-coded output enabled by defining T_TOGGLE_COUNTER_GRAY_EN.
module t_toggle_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
`ifdef T_TOGGLE_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic             busy_dir
);

    localparam logic [WIDTH-1:0] LastVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_dir;

    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_q_d;
    logic             w_wrap;

    // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
    assign w_toggle[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign w_toggle[i] = up_dn ? (&r_q[i-1:0]) : ~(|r_q[i-1:0]);
    end

    always_comb begin
        w_wrap   = up_dn ? (r_q == LastVal) : (r_q == '0);
        w_count  = r_q ^ w_toggle;
        if (w_wrap) begin
            w_count = up_dn ? '0 : LastVal;
        end
        w_load_q = (32'(load_val) < MODULUS) ? load_val : LastVal;

        w_q_d = r_q;
        if (load) begin
            w_q_d = w_load_q;
        end else if (en) begin
            w_q_d = w_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_dir <= 1'b1;
        end else begin
            r_q  <= w_q_d;
            r_tc <= ~load & en & w_wrap;
            if (!load && en) begin
                r_dir <= up_dn;
            end
        end
    end

    assign q        = r_q;
    assign tc       = r_tc;
    assign busy_dir = r_dir;

`ifdef T_TOGGLE_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_q_gray;

    // Encoded from the next-state value so it lands on the same edge as q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_gray <= '0;
        end else begin
            r_q_gray <= w_q_d ^ (w_q_d >> 1);
        end
    end

    assign q_gray = r_q_gray;
`endif

endmodule

// File: tb/tb_t_toggle_counter.sv
// Scoreboard bench: two counters (MODULUS 10 and 16) driven in lockstep against an arithmetic model.
// Gray output is also checked when T_TOGGLE_COUNTER_GRAY_EN is defined.
module tb_t_toggle_counter;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, dir_a, dir_b;
`ifdef T_TOGGLE_COUNTER_GRAY_EN
    logic [3:0] gray_a, gray_b;
`endif

    int total = 0;
    int bad   = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   m_q[2];
    int   m_dir[2];

    always #5 clk = ~clk;

    t_toggle_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q_a),
        .tc       (tc_a),
`ifdef T_TOGGLE_COUNTER_GRAY_EN
        .q_gray   (gray_a),
`endif
        .busy_dir (dir_a)
    );

    t_toggle_counter #(.WIDTH(4), .MODULUS(16)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q_b),
        .tc       (tc_b),
`ifdef T_TOGGLE_COUNTER_GRAY_EN
        .q_gray   (gray_b),
`endif
        .busy_dir (dir_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int k, input int modulus, input logic r,
                                   input logic l, input logic e, input logic u,
                                   input logic [3:0] lv);
        exp_t o;
        int   t;
        t = 0;
        if (r) begin
            m_q[k]   = 0;
            m_dir[k] = 1;
        end else if (l) begin
            m_q[k] = (int'(lv) < modulus) ? int'(lv) : modulus - 1;
        end else if (e) begin
            m_dir[k] = int'(u);
            if (u) begin
                if (m_q[k] == modulus - 1) begin
                    m_q[k] = 0;
                    t      = 1;
                end else begin
                    m_q[k] = m_q[k] + 1;
                end
            end else begin
                if (m_q[k] == 0) begin
                    m_q[k] = modulus - 1;
                    t      = 1;
                end else begin
                    m_q[k] = m_q[k] - 1;
                end
            end
        end
        o.q   = 4'(m_q[k]);
        o.tc  = t[0];
        o.dir = m_dir[k][0];
        return o;
    endfunction

    task automatic compare_one(input string name, input int k, input logic [3:0] gq,
                               input logic gtc, input logic gdir, input logic [3:0] gg);
        exp_t e;
        if (k == 0) begin
            if (sb_a.size() == 0) begin
                check({name, "_sb_empty"}, 1, 0);
                return;
            end
            e = sb_a.pop_front();
        end else begin
            if (sb_b.size() == 0) begin
                check({name, "_sb_empty"}, 1, 0);
                return;
            end
            e = sb_b.pop_front();
        end
        check({name, "_q"}, int'(gq), int'(e.q));
        check({name, "_tc"}, int'(gtc), int'(e.tc));
        check({name, "_dir"}, int'(gdir), int'(e.dir));
`ifdef T_TOGGLE_COUNTER_GRAY_EN
        check({name, "_gray"}, int'(gg), int'(e.q ^ (e.q >> 1)));
`else
        if (gg != 4'd0) check({name, "_gray_unused"}, int'(gg), 0);
`endif
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] lv);
        logic [3:0] ga, gb;
        rst      = r;
        load     = l;
        en       = e;
        up_dn    = u;
        load_val = lv;
        sb_a.push_back(model(0, 10, r, l, e, u, lv));
        sb_b.push_back(model(1, 16, r, l, e, u, lv));
        @(posedge clk);
        #1;
`ifdef T_TOGGLE_COUNTER_GRAY_EN
        ga = gray_a;
        gb = gray_b;
`else
        ga = 4'd0;
        gb = 4'd0;
`endif
        compare_one("m10", 0, q_a, tc_a, dir_a, ga);
        compare_one("m16", 1, q_b, tc_b, dir_b, gb);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_q   = '{0, 0};
        m_dir = '{1, 1};
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        @(posedge clk);
        #1;

        // Reset followed by up-count across the modulus-10 wrap.
        step(1, 0, 0, 1, 0);
        check("reset_q", int'(q_a), 0);
        check("reset_dir", int'(dir_a), 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
        check("up12_q", int'(q_a), 2);

        // Down-wrap straight out of reset.
        step(1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        check("down_wrap_q", int'(q_a), 9);
        check("down_wrap_tc", int'(tc_a), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // Load clamp with en also high, then wrap up.
        step(0, 1, 1, 1, 4'd13);
        check("clamp_q", int'(q_a), 9);
        check("clamp_tc", int'(tc_a), 0);
        step(0, 0, 1, 1, 0);
        check("clamp_wrap_tc", int'(tc_a), 1);

        // Reset beats load mid-count, then resume.
        step(0, 1, 0, 1, 4'd6);
        step(1, 1, 1, 0, 4'd3);
        check("rst_prio_q", int'(q_a), 0);
        step(0, 0, 1, 1, 0);
        check("resume_q", int'(q_a), 1);
        check("resume_tc", int'(tc_a), 0);
        step(0, 0, 1, 1, 0);

        // Full-modulus corner on the 16-state counter, then hold.
        step(0, 1, 0, 1, 4'd15);
        step(0, 0, 1, 1, 0);
        check("full_wrap_q", int'(q_b), 0);
        check("full_wrap_tc", int'(tc_b), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("hold_q", int'(q_b), 0);

        // Gray sequence 0..9 on the modulus-10 counter.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 0);

        // Random mix including direction flips while enabled.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t_toggle_counter.md
T_TOGGLE_COUNTER -- requirements
Module: t_toggle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter bit width, legal range 1..16.
REQ-002 SHALL have parameter MODULUS, default 16: count modulus, legal range 2..2^WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: count enable; when low the count holds.
REQ-006 SHALL have port up_dn, input, 1: direction; 1 = count up, 0 = count down.
REQ-007 SHALL have port load, input, 1: synchronous parallel-load strobe.
REQ-008 SHALL have port load_val, input, WIDTH: value to load when load is high.
REQ-009 SHALL have port q, output reg, WIDTH: current count.
REQ-010 SHALL have port tc, output reg, 1: wrap pulse, high for one cycle after a wrap.
REQ-011 SHALL have port busy_dir, output reg, 1: registered copy of the last direction used for counting.

Function
REQ-012 SHALL resolve controls per edge in priority order: rst > load > en > hold.
REQ-013 SHALL, on load=1, set q to load_val when load_val < MODULUS, else to MODULUS-1 (clamp).
REQ-014 SHALL, on load=1, force tc=0 and leave busy_dir unchanged.
REQ-015 SHALL, on en=1 with up_dn=1, set q to q+1, or to 0 when q==MODULUS-1.
REQ-016 SHALL, on en=1 with up_dn=0, set q to q-1, or to MODULUS-1 when q==0.
REQ-017 SHALL set tc=1 on the edge that performs a wrap (up: MODULUS-1->0; down: 0->MODULUS-1), so tc is high in the same cycle q shows the wrapped value.
REQ-018 SHALL set tc=0 on every edge that does not perform a wrap.
REQ-019 SHALL, on en=0 with load=0, hold q and busy_dir and set tc=0.
REQ-020 SHALL update busy_dir to up_dn on every edge with en=1 and load=0.
REQ-021 SHALL compute q as a bank of WIDTH toggle flip-flops: bit i toggles when its toggle term is true.
- Up toggle term: all lower bits are 1.
- Down toggle term: all lower bits are 0.
- Modulus wrap overrides the toggle terms, with all bits written directly.
REQ-022 SHALL, when MODULUS==2^WIDTH, wrap naturally with no compare logic changing the result.
REQ-023 SHALL, if up_dn changes while en=1, use the new direction on that same edge, with no dead cycle.
REQ-024 SHALL reach only states 0..MODULUS-1 from any input sequence after reset.

Reset
REQ-025 SHALL, on rst=1 at a rising clk edge, set q=0, tc=0 and busy_dir=1, regardless of load or en.
REQ-026 SHALL, when rst is asserted mid-count, make the counter resume from 0 on the first edge after rst deasserts, and that edge SHALL NOT produce a tc pulse.
REQ-027 SHALL have no asynchronous path from rst to any output.

Configuration
REQ-028 SHALL, when macro T_TOGGLE_COUNTER_GRAY_EN is defined, add output reg q_gray[WIDTH-1:0].
- q_gray holds the Gray code of q: q_gray = q ^ (q >> 1).
- q_gray is registered and cycle-aligned with q.
- q_gray resets to 0.
REQ-029 SHALL, when T_TOGGLE_COUNTER_GRAY_EN is undefined, omit the q_gray port and its logic entirely, leaving all other behaviour identical.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-030 SHALL check reset then up-count: rst 1 cycle, en=1, up_dn=1 for 12 cycles -> q = 1..9, 0, 1, 2, with tc=1 only in the cycle q==0 after 9.
REQ-031 SHALL check down-wrap: from reset, en=1, up_dn=0 -> q=9 on the first edge with tc=1, then 8, 7, ... with tc=0.
REQ-032 SHALL check load clamp and priority: load=1, load_val=13, en=1 -> q=9 and tc=0; next edge with en=1, up_dn=1 -> q=0 and tc=1.
REQ-033 SHALL check reset mid-operation: q=6, rst=1 with load=1, load_val=3 -> q=0, tc=0, busy_dir=1; counting resumes 1, 2, ...
REQ-034 SHALL check the full-modulus corner: WIDTH=4, MODULUS=16 -> up from 15 gives q=0 with tc=1; hold with en=0 for 3 cycles -> q stable and tc=0.
REQ-035 SHALL check the Gray build: with T_TOGGLE_COUNTER_GRAY_EN defined, run 0..9 up -> q_gray = 0, 1, 3, 2, 6, 7, 5, 4, 12, 13 aligned with q.
